// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and the two-requester ALU arbiter:
// ALU control codes and the arbiter FSM state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU. Unknown control codes produce y=0, which also
// sets zero=1.
module alu
    import alu_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [3:0]  ctrl_i,
    output logic [31:0] y_o,
    output logic        zero_o
);

    always_comb begin
        y_o = '0;
        case (ctrl_i)
            ALU_AND: y_o = a_i & b_i;
            ALU_OR:  y_o = a_i | b_i;
            ALU_ADD: y_o = a_i + b_i;
            ALU_SUB: y_o = a_i - b_i;
            ALU_SLT: y_o = {31'b0, ($signed(a_i) < $signed(b_i))};
            default: y_o = '0;
        endcase
        zero_o = (y_o == '0);
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU through an IDLE -> EXEC -> RESP handshake FSM,
// with round-robin or fixed-priority arbitration chosen by RR_EN.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int RR_EN = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [3:0]  req0_ctrl,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req1_ctrl,

    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_y,
    output logic        rsp0_zero,

    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_y,
    output logic        rsp1_zero,

    output logic        busy
);

    arb_state_e  state_q, state_d;
    logic        grant_q, grant_d;
    logic        lastGrant_q, lastGrant_d;
    logic [31:0] operandA_q, operandA_d;
    logic [31:0] operandB_q, operandB_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] rsp0Y_q, rsp0Y_d;
    logic        rsp0Zero_q, rsp0Zero_d;
    logic [31:0] rsp1Y_q, rsp1Y_d;
    logic        rsp1Zero_q, rsp1Zero_d;

    logic        pick;
    logic        anyValid;
    logic        grantReady;
    logic [31:0] aluY;
    logic        aluZero;

    alu u_alu (
        .a_i    (operandA_q),
        .b_i    (operandB_q),
        .ctrl_i (ctrl_q),
        .y_o    (aluY),
        .zero_o (aluZero)
    );

    // A tie goes to whoever was not served last in round-robin mode;
    // otherwise requester 0 wins whenever it is valid.
    assign anyValid   = req0_valid | req1_valid;
    assign pick       = ((RR_EN != 0) && req0_valid && req1_valid) ? ~lastGrant_q : ~req0_valid;
    assign grantReady = grant_q ? rsp1_ready : rsp0_ready;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        lastGrant_d = lastGrant_q;
        operandA_d  = operandA_q;
        operandB_d  = operandB_q;
        ctrl_d      = ctrl_q;
        rsp0Y_d     = rsp0Y_q;
        rsp0Zero_d  = rsp0Zero_q;
        rsp1Y_d     = rsp1Y_q;
        rsp1Zero_d  = rsp1Zero_q;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rst && anyValid) begin
                    req0_ready  = ~pick;
                    req1_ready  = pick;
                    grant_d     = pick;
                    lastGrant_d = pick;
                    operandA_d  = pick ? req1_a : req0_a;
                    operandB_d  = pick ? req1_b : req0_b;
                    ctrl_d      = pick ? req1_ctrl : req0_ctrl;
                    state_d     = EXEC;
                end
            end
            EXEC: begin
                if (grant_q) begin
                    rsp1Y_d    = aluY;
                    rsp1Zero_d = aluZero;
                end else begin
                    rsp0Y_d    = aluY;
                    rsp0Zero_d = aluZero;
                end
                state_d = RESP;
            end
            RESP: begin
                if (grantReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= 1'b0;
            lastGrant_q <= 1'b1;
            operandA_q  <= '0;
            operandB_q  <= '0;
            ctrl_q      <= '0;
            rsp0Y_q     <= '0;
            rsp0Zero_q  <= 1'b1;
            rsp1Y_q     <= '0;
            rsp1Zero_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            lastGrant_q <= lastGrant_d;
            operandA_q  <= operandA_d;
            operandB_q  <= operandB_d;
            ctrl_q      <= ctrl_d;
            rsp0Y_q     <= rsp0Y_d;
            rsp0Zero_q  <= rsp0Zero_d;
            rsp1Y_q     <= rsp1Y_d;
            rsp1Zero_q  <= rsp1Zero_d;
        end
    end

    assign rsp0_valid = (state_q == RESP) && !grant_q;
    assign rsp1_valid = (state_q == RESP) &&  grant_q;
    assign rsp0_y     = rsp0Y_q;
    assign rsp0_zero  = rsp0Zero_q;
    assign rsp1_y     = rsp1Y_q;
    assign rsp1_zero  = rsp1Zero_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a round-robin instance and a fixed-priority
// instance share the same stimulus, each scenario checks its own outputs.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]  req0_ctrl = '0, req1_ctrl = '0;
    logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;

    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_zero, rsp1_zero, busy;
    logic [31:0] rsp0_y, rsp1_y;
    logic        fp_req0_ready, fp_req1_ready, fp_rsp0_valid, fp_rsp1_valid;
    logic        fp_rsp0_zero, fp_rsp1_zero, fp_busy;
    logic [31:0] fp_rsp0_y, fp_rsp1_y;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.RR_EN(1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_y(rsp0_y), .rsp0_zero(rsp0_zero),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_y(rsp1_y), .rsp1_zero(rsp1_zero),
        .busy(busy)
    );

    alu_arbiter #(.RR_EN(0)) dut_fp (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
        .rsp0_valid(fp_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_y(fp_rsp0_y), .rsp0_zero(fp_rsp0_zero),
        .rsp1_valid(fp_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_y(fp_rsp1_y), .rsp1_zero(fp_rsp1_zero),
        .busy(fp_busy)
    );

    // Advance one clock and settle 1 time unit past the rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        cycle();
        cycle();
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            fails++; $display("[TB] FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready});
        end
        checks++;
        if ({busy, rsp0_valid, rsp1_valid} !== 3'b000) begin
            fails++; $display("[TB] FAIL reset_busy_valid: got %b expected 000", {busy, rsp0_valid, rsp1_valid});
        end
        checks++;
        if (rsp0_y !== 32'd0 || rsp1_y !== 32'd0 || rsp0_zero !== 1'b1 || rsp1_zero !== 1'b1) begin
            fails++; $display("[TB] FAIL reset_rsp_data: got y0=%h y1=%h z0=%b z1=%b expected 0/0/1/1",
                              rsp0_y, rsp1_y, rsp0_zero, rsp1_zero);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_single_add();
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        req0_a = 32'd5; req0_b = 32'd3; req0_ctrl = 4'b0010;
        req0_valid = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            fails++; $display("[TB] FAIL single_ready: got %b expected 10", {req0_ready, req1_ready});
        end
        cycle();
        req0_valid = 1'b0;
        checks++;
        if ({busy, req0_ready, rsp0_valid} !== 3'b100) begin
            fails++; $display("[TB] FAIL single_exec: got busy/ready/valid=%b expected 100", {busy, req0_ready, rsp0_valid});
        end
        cycle();
        checks++;
        if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp0_y !== 32'd8 || rsp0_zero !== 1'b0) begin
            fails++; $display("[TB] FAIL single_rsp: got v0=%b v1=%b y=%0d z=%b expected 1 0 8 0",
                              rsp0_valid, rsp1_valid, rsp0_y, rsp0_zero);
        end
        cycle();
        checks++;
        if (busy !== 1'b0 || rsp0_valid !== 1'b0) begin
            fails++; $display("[TB] FAIL single_idle: got busy=%b v0=%b expected 0 0", busy, rsp0_valid);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        req0_a = 32'd7; req0_b = 32'd7; req0_ctrl = 4'b0110;
        req1_a = 32'hFFFF_FFFF; req1_b = 32'd1; req1_ctrl = 4'b0111;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            fails++; $display("[TB] FAIL rr_first_grant: got %b expected 10", {req0_ready, req1_ready});
        end
        cycle();
        cycle();
        checks++;
        if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp0_y !== 32'd0 || rsp0_zero !== 1'b1) begin
            fails++; $display("[TB] FAIL rr_sub_rsp: got v0=%b v1=%b y=%h z=%b expected 1 0 0 1",
                              rsp0_valid, rsp1_valid, rsp0_y, rsp0_zero);
        end
        cycle();
        checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            fails++; $display("[TB] FAIL rr_second_grant: got %b expected 01", {req0_ready, req1_ready});
        end
        cycle();
        cycle();
        checks++;
        if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp1_y !== 32'd1 || rsp1_zero !== 1'b0) begin
            fails++; $display("[TB] FAIL rr_slt_rsp: got v1=%b v0=%b y=%h z=%b expected 1 0 1 0",
                              rsp1_valid, rsp0_valid, rsp1_y, rsp1_zero);
        end
        checks++;
        if (rsp0_y !== 32'd0 || rsp0_zero !== 1'b1) begin
            fails++; $display("[TB] FAIL rr_other_hold: got y0=%h z0=%b expected 0 1", rsp0_y, rsp0_zero);
        end
        cycle();
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            fails++; $display("[TB] FAIL rr_third_grant: got %b expected 10", {req0_ready, req1_ready});
        end
        cycle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        cycle();
        cycle();
    endtask

    task automatic test_backpressure();
        rsp1_ready = 1'b0;
        req1_a = 32'd10; req1_b = 32'd3; req1_ctrl = 4'b0110;
        req1_valid = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            fails++; $display("[TB] FAIL bp_grant: got %b expected 01", {req0_ready, req1_ready});
        end
        cycle();
        req1_valid = 1'b0;
        req0_a = 32'd1; req0_b = 32'd1; req0_ctrl = 4'b0010;
        req0_valid = 1'b1;
        cycle();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp1_valid !== 1'b1 || rsp1_y !== 32'd7 || req0_ready !== 1'b0 || busy !== 1'b1) begin
                fails++; $display("[TB] FAIL bp_hold[%0d]: got v1=%b y=%0d r0=%b busy=%b expected 1 7 0 1",
                                  i, rsp1_valid, rsp1_y, req0_ready, busy);
            end
            cycle();
        end
        rsp1_ready = 1'b1;
        #1;
        checks++;
        if (rsp1_valid !== 1'b1 || rsp1_y !== 32'd7) begin
            fails++; $display("[TB] FAIL bp_release: got v1=%b y=%0d expected 1 7", rsp1_valid, rsp1_y);
        end
        cycle();
        checks++;
        if (busy !== 1'b0 || rsp1_valid !== 1'b0 || req0_ready !== 1'b1) begin
            fails++; $display("[TB] FAIL bp_idle: got busy=%b v1=%b r0=%b expected 0 0 1", busy, rsp1_valid, req0_ready);
        end
        cycle();
        req0_valid = 1'b0;
        cycle();
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_y !== 32'd2) begin
            fails++; $display("[TB] FAIL bp_stalled_req: got v0=%b y=%0d expected 1 2", rsp0_valid, rsp0_y);
        end
        cycle();
    endtask

    task automatic test_invalid_ctrl();
        rsp0_ready = 1'b1;
        req0_a = 32'hA; req0_b = 32'hB; req0_ctrl = 4'b1111;
        req0_valid = 1'b1;
        cycle();
        req0_valid = 1'b0;
        cycle();
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_y !== 32'd0 || rsp0_zero !== 1'b1) begin
            fails++; $display("[TB] FAIL invalid_ctrl: got v0=%b y=%h z=%b expected 1 0 1", rsp0_valid, rsp0_y, rsp0_zero);
        end
        cycle();
    endtask

    task automatic test_reset_in_exec();
        req0_a = 32'd1; req0_b = 32'd1; req0_ctrl = 4'b0010;
        req0_valid = 1'b1;
        cycle();
        req0_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            fails++; $display("[TB] FAIL rst_exec_pre: got busy=%b expected 1", busy);
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp0_y !== 32'd0) begin
            fails++; $display("[TB] FAIL rst_exec_idle: got busy=%b v0=%b y=%h expected 0 0 0", busy, rsp0_valid, rsp0_y);
        end
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
                fails++; $display("[TB] FAIL rst_exec_no_rsp[%0d]: got v0=%b v1=%b expected 0 0", i, rsp0_valid, rsp1_valid);
            end
        end
    endtask

    task automatic test_fixed_priority();
        do_reset();
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        req1_a = 32'd100; req1_b = 32'd1; req1_ctrl = 4'b0010;
        req0_b = 32'd10; req0_ctrl = 4'b0010;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req0_a = i;
            #1;
            checks++;
            if ({fp_req0_ready, fp_req1_ready} !== 2'b10) begin
                fails++; $display("[TB] FAIL fp_grant[%0d]: got %b expected 10", i, {fp_req0_ready, fp_req1_ready});
            end
            cycle();
            cycle();
            checks++;
            if (fp_rsp0_valid !== 1'b1 || fp_rsp1_valid !== 1'b0 || fp_rsp0_y !== 32'(i + 10)) begin
                fails++; $display("[TB] FAIL fp_rsp[%0d]: got v0=%b v1=%b y=%0d expected 1 0 %0d",
                                  i, fp_rsp0_valid, fp_rsp1_valid, fp_rsp0_y, i + 10);
            end
            cycle();
        end
        checks++;
        if (fp_rsp1_y !== 32'd0 || fp_rsp1_zero !== 1'b1) begin
            fails++; $display("[TB] FAIL fp_starve: got y1=%h z1=%b expected 0 1", fp_rsp1_y, fp_rsp1_zero);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        cycle();
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_round_robin();
        test_backpressure();
        test_invalid_ctrl();
        test_reset_in_exec();
        test_fixed_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
